// File: rtl/max7219_sched.sv
`timescale 1ns/1ps
// max7219_sched: word-level scheduler for a MAX7219 serial link.
// Arbitrates the power-up configuration, digit refresh frames and host raw
// writes onto one 16-bit {addr, data} stream with a valid/ready handshake.
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   intensity/scan_limit/decode_mode  configuration values (regs 0x0A/0x0B/0x09)
//   digits               digit bytes, digit n -> register n+1
//   disp_update          one-cycle refresh request
//   cmd_valid/cmd_word/cmd_ready      host word handshake
//   word_valid/word_data/word_ready   word stream to the bit-serial shifter
//   init_done            init sequence complete
//   busy                 scheduler is not idle
module max7219_sched #(
  parameter int REFRESH_CYCLES = 1000000,
  parameter int NUM_DIGITS     = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  intensity,
  input  logic [2:0]  scan_limit,
  input  logic [7:0]  decode_mode,
  input  logic [63:0] digits,
  input  logic        disp_update,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_word,
  output logic        cmd_ready,
  output logic        word_valid,
  output logic [15:0] word_data,
  input  logic        word_ready,
  output logic        init_done,
  output logic        busy
);

  localparam int              CNT_W      = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]      LAST_DIGIT = 4'(NUM_DIGITS);
  localparam logic [3:0]      INIT_WORDS = 4'd5;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CFG     = 3'd2,
    ST_HOST    = 3'd3,
    ST_REFRESH = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         index_r, index_s;
  logic               word_valid_r;
  logic [15:0]        word_data_r;
  logic               init_done_r;
  logic               refresh_pending_r;
  logic               rr_last_r;          // 1: host served last, 0: refresh
  logic [CNT_W-1:0]   refresh_cnt_r;
  logic [7:0]         sh_decode_r;
  logic [3:0]         sh_intensity_r;
  logic [2:0]         sh_scan_r;
  logic [63:0]        frame_r;
  logic               busy_r;

  logic               xfer_s, can_load_s, tick_s;
  logic               diff_dec_s, diff_int_s, diff_scan_s, cfg_pend_s;
  logic [15:0]        cfg_word_s, init_word_s, load_word_s;
  logic [2:0]         cfg_upd_s;          // {scan, intensity, decode}
  logic               load_s, upd_dec_s, upd_int_s, upd_scan_s;
  logic               done_init_s, frame_start_s, frame_end_s, host_end_s;
  logic               cmd_accept_s;

  assign xfer_s       = word_valid_r & word_ready;
  // A new word may load into an empty slot or into the slot being drained.
  assign can_load_s   = ~word_valid_r | word_ready;
  assign tick_s       = init_done_r & (refresh_cnt_r == CNT_LAST);
  assign diff_dec_s   = (decode_mode != sh_decode_r);
  assign diff_int_s   = (intensity   != sh_intensity_r);
  assign diff_scan_s  = (scan_limit  != sh_scan_r);
  assign cfg_pend_s   = diff_dec_s | diff_int_s | diff_scan_s;
  // Host is blocked while refresh waits and host was the last one served.
  assign cmd_ready    = (state_r == ST_IDLE) & init_done_r & ~cfg_pend_s &
                        (~refresh_pending_r | ~rr_last_r);
  assign cmd_accept_s = cmd_valid & cmd_ready;

  assign word_valid = word_valid_r;
  assign word_data  = word_data_r;
  assign init_done  = init_done_r;
  assign busy       = busy_r;

  // Pick the first changed config register in order 0x09, 0x0A, 0x0B.
  always_comb begin
    cfg_word_s = 16'h0000;
    cfg_upd_s  = 3'b000;
    if (diff_dec_s) begin
      cfg_word_s = {8'h09, decode_mode};
      cfg_upd_s  = 3'b001;
    end else if (diff_int_s) begin
      cfg_word_s = {8'h0A, 4'h0, intensity};
      cfg_upd_s  = 3'b010;
    end else if (diff_scan_s) begin
      cfg_word_s = {8'h0B, 5'b00000, scan_limit};
      cfg_upd_s  = 3'b100;
    end else begin
      cfg_word_s = 16'h0000;
      cfg_upd_s  = 3'b000;
    end
  end

  // Power-up word table indexed by position in the init sequence.
  always_comb begin
    init_word_s = 16'h0000;
    case (index_r)
      4'd0:    init_word_s = 16'h0F00;
      4'd1:    init_word_s = 16'h0C01;
      4'd2:    init_word_s = {8'h09, decode_mode};
      4'd3:    init_word_s = {8'h0A, 4'h0, intensity};
      4'd4:    init_word_s = {8'h0B, 5'b00000, scan_limit};
      default: init_word_s = 16'h0000;
    endcase
  end

  // Next-state logic and word-load decisions.
  always_comb begin
    state_s       = state_r;
    index_s       = index_r;
    load_s        = 1'b0;
    load_word_s   = 16'h0000;
    upd_dec_s     = 1'b0;
    upd_int_s     = 1'b0;
    upd_scan_s    = 1'b0;
    done_init_s   = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    host_end_s    = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (xfer_s && (index_r == INIT_WORDS)) begin
          done_init_s = 1'b1;
          index_s     = 4'd0;
          state_s     = ST_IDLE;
        end else if (can_load_s && (index_r < INIT_WORDS)) begin
          load_s      = 1'b1;
          load_word_s = init_word_s;
          upd_dec_s   = (index_r == 4'd2);
          upd_int_s   = (index_r == 4'd3);
          upd_scan_s  = (index_r == 4'd4);
          index_s     = index_r + 4'd1;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (cfg_pend_s) begin
          load_s      = 1'b1;
          load_word_s = cfg_word_s;
          upd_dec_s   = cfg_upd_s[0];
          upd_int_s   = cfg_upd_s[1];
          upd_scan_s  = cfg_upd_s[2];
          state_s     = ST_CFG;
        end else if (cmd_accept_s) begin
          load_s      = 1'b1;
          load_word_s = cmd_word;
          state_s     = ST_HOST;
        end else if (refresh_pending_r) begin
          // First digit comes straight from the inputs; the snapshot covers the rest.
          frame_start_s = 1'b1;
          load_s        = 1'b1;
          load_word_s   = {8'h01, digits[7:0]};
          index_s       = 4'd1;
          state_s       = ST_REFRESH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CFG: begin
        if (xfer_s) begin
          if (cfg_pend_s) begin
            load_s      = 1'b1;
            load_word_s = cfg_word_s;
            upd_dec_s   = cfg_upd_s[0];
            upd_int_s   = cfg_upd_s[1];
            upd_scan_s  = cfg_upd_s[2];
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_CFG;
        end
      end
      ST_HOST: begin
        if (xfer_s) begin
          host_end_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_HOST;
        end
      end
      ST_REFRESH: begin
        if (xfer_s) begin
          if (index_r == LAST_DIGIT) begin
            frame_end_s = 1'b1;
            index_s     = 4'd0;
            state_s     = ST_IDLE;
          end else begin
            load_s      = 1'b1;
            load_word_s = {4'h0, index_r + 4'd1, frame_r[{index_r[2:0], 3'b000} +: 8]};
            index_s     = index_r + 4'd1;
          end
        end else begin
          state_s = ST_REFRESH;
        end
      end
      default: begin
        state_s = ST_INIT;
        index_s = 4'd0;
      end
    endcase
  end

  // State, word slot, shadows, arbitration and refresh timer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r           <= ST_INIT;
      index_r           <= 4'd0;
      word_valid_r      <= 1'b0;
      word_data_r       <= 16'h0000;
      init_done_r       <= 1'b0;
      refresh_pending_r <= 1'b0;
      rr_last_r         <= 1'b0;
      refresh_cnt_r     <= '0;
      sh_decode_r       <= 8'h00;
      sh_intensity_r    <= 4'h0;
      sh_scan_r         <= 3'b000;
      frame_r           <= 64'h0;
      busy_r            <= 1'b1;
    end else begin
      state_r <= state_s;
      index_r <= index_s;
      busy_r  <= (state_s != ST_IDLE);

      if (load_s) begin
        word_valid_r <= 1'b1;
        word_data_r  <= load_word_s;
      end else if (xfer_s) begin
        word_valid_r <= 1'b0;
      end else begin
        word_valid_r <= word_valid_r;
      end

      if (done_init_s) begin
        init_done_r <= 1'b1;
      end else begin
        init_done_r <= init_done_r;
      end

      // New requests win over the clear so a request at frame entry yields one more frame.
      if (tick_s || disp_update || done_init_s) begin
        refresh_pending_r <= 1'b1;
      end else if (frame_start_s) begin
        refresh_pending_r <= 1'b0;
      end else begin
        refresh_pending_r <= refresh_pending_r;
      end

      if (host_end_s) begin
        rr_last_r <= 1'b1;
      end else if (frame_end_s) begin
        rr_last_r <= 1'b0;
      end else begin
        rr_last_r <= rr_last_r;
      end

      if (tick_s) begin
        refresh_cnt_r <= '0;
      end else if (init_done_r) begin
        refresh_cnt_r <= refresh_cnt_r + CNT_ONE;
      end else begin
        refresh_cnt_r <= refresh_cnt_r;
      end

      if (frame_start_s) begin
        frame_r <= digits;
      end else begin
        frame_r <= frame_r;
      end

      if (upd_dec_s) begin
        sh_decode_r <= decode_mode;
      end else begin
        sh_decode_r <= sh_decode_r;
      end
      if (upd_int_s) begin
        sh_intensity_r <= intensity;
      end else begin
        sh_intensity_r <= sh_intensity_r;
      end
      if (upd_scan_s) begin
        sh_scan_r <= scan_limit;
      end else begin
        sh_scan_r <= sh_scan_r;
      end
    end
  end

endmodule

// File: tb/tb_max7219_sched.sv
`timescale 1ns/1ps
module tb_max7219_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic [7:0]  decode_mode;
  logic [63:0] digits;
  logic        disp_update;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        cmd_ready;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;
  logic        init_done;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  max7219_sched #(.REFRESH_CYCLES(3000), .NUM_DIGITS(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .intensity  (intensity),
    .scan_limit (scan_limit),
    .decode_mode(decode_mode),
    .digits     (digits),
    .disp_update(disp_update),
    .cmd_valid  (cmd_valid),
    .cmd_word   (cmd_word),
    .cmd_ready  (cmd_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .init_done  (init_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next word, check it, then step past its transfer edge.
  task automatic expect_word(input string tag, input logic [15:0] exp);
    int n = 0;
    while (word_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {15'd0, word_valid}, 16'd1);
    chk(tag, word_data, exp);
    @(negedge clk);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (word_valid !== 1'b0) seen++;
    end
    chk({tag, "_nowords"}, 16'(seen), 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic pulse_update();
    disp_update = 1'b1;
    @(negedge clk);
    disp_update = 1'b0;
  endtask

  initial begin
    int bad;
    int c0;
    int n;
    resetn      = 1'b0;
    word_ready  = 1'b1;
    intensity   = 4'h8;
    scan_limit  = 3'd7;
    decode_mode = 8'h00;
    digits      = 64'h8877665544332211;
    disp_update = 1'b0;
    cmd_valid   = 1'b0;
    cmd_word    = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_word_valid", {15'd0, word_valid}, 16'd0);
    chk("rst_word_data", word_data, 16'h0000);
    chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    chk("rst_init_done", {15'd0, init_done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd1);
    resetn = 1'b1;

    // Power-up sequence followed by the first frame
    expect_word("init0", 16'h0F00);
    expect_word("init1", 16'h0C01);
    expect_word("init2", 16'h0900);
    expect_word("init3", 16'h0A08);
    chk("init_done_early", {15'd0, init_done}, 16'd0);
    expect_word("init4", 16'h0B07);
    chk("init_done_set", {15'd0, init_done}, 16'd1);
    expect_word("f0_d1", 16'h0111);
    expect_word("f0_d2", 16'h0222);
    expect_word("f0_d3", 16'h0333);
    expect_word("f0_d4", 16'h0444);
    expect_word("f0_d5", 16'h0555);
    expect_word("f0_d6", 16'h0666);
    expect_word("f0_d7", 16'h0777);
    expect_word("f0_d8", 16'h0888);
    expect_quiet("f0_end", 10);

    // On-demand refresh
    digits = 64'h0807060504030201;
    pulse_update();
    chk("f1_busy_before", {15'd0, busy}, 16'd0);
    expect_word("f1_d1", 16'h0101);
    chk("f1_busy", {15'd0, busy}, 16'd1);
    expect_word("f1_d2", 16'h0202);
    expect_word("f1_d3", 16'h0303);
    expect_word("f1_d4", 16'h0404);
    expect_word("f1_d5", 16'h0505);
    expect_word("f1_d6", 16'h0606);
    expect_word("f1_d7", 16'h0707);
    expect_word("f1_d8", 16'h0808);
    expect_quiet("f1_end", 10);

    // Intensity and digits change mid-frame: frame uses its snapshot, then one 0A word
    digits = 64'h8070605040302010;
    pulse_update();
    expect_word("f2_d1", 16'h0110);
    expect_word("f2_d2", 16'h0220);
    intensity = 4'h3;
    digits    = 64'hFFFFFFFFFFFFFFFF;
    expect_word("f2_d3", 16'h0330);
    expect_word("f2_d4", 16'h0440);
    expect_word("f2_d5", 16'h0550);
    expect_word("f2_d6", 16'h0660);
    expect_word("f2_d7", 16'h0770);
    expect_word("f2_d8", 16'h0880);
    expect_word("cfg_int", 16'h0A03);
    expect_quiet("cfg_end", 10);

    // Host and refresh requested together with refresh served last
    chk("rr_ready_idle", {15'd0, cmd_ready}, 16'd1);
    digits      = 64'h0102030405060708;
    cmd_valid   = 1'b1;
    cmd_word    = 16'h0A0F;
    disp_update = 1'b1;
    @(negedge clk);
    disp_update = 1'b0;
    cmd_word    = 16'h0A05;
    chk("rr_ready_host", {15'd0, cmd_ready}, 16'd0);
    expect_word("rr_host0", 16'h0A0F);
    chk("rr_blocks_host", {15'd0, cmd_ready}, 16'd0);
    expect_word("rr_d1", 16'h0108);
    expect_word("rr_d2", 16'h0207);
    expect_word("rr_d3", 16'h0306);
    expect_word("rr_d4", 16'h0405);
    expect_word("rr_d5", 16'h0504);
    expect_word("rr_d6", 16'h0603);
    expect_word("rr_d7", 16'h0702);
    expect_word("rr_d8", 16'h0801);
    expect_word("rr_host1", 16'h0A05);
    cmd_valid = 1'b0;
    expect_quiet("rr_end", 10);

    // Downstream stall mid-frame
    digits = 64'hF7E6D5C4B3A29180;
    pulse_update();
    expect_word("st_d1", 16'h0180);
    expect_word("st_d2", 16'h0291);
    expect_word("st_d3", 16'h03A2);
    word_ready = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (word_valid !== 1'b1 || word_data !== 16'h04B3) bad++;
    end
    chk("stall_stable", 16'(bad), 16'd0);
    chk("stall_busy", {15'd0, busy}, 16'd1);
    word_ready = 1'b1;
    expect_word("st_d4", 16'h04B3);
    expect_word("st_d5", 16'h05C4);
    expect_word("st_d6", 16'h06D5);
    expect_word("st_d7", 16'h07E6);
    expect_word("st_d8", 16'h08F7);
    expect_quiet("st_end", 10);

    // Reset during the third digit word
    digits = 64'h1122334455667788;
    pulse_update();
    expect_word("rs_d1", 16'h0188);
    expect_word("rs_d2", 16'h0277);
    chk("rs_d3_pending", word_data, 16'h0366);
    #2;
    resetn = 1'b0;
    #1;
    chk("rs_valid_drop", {15'd0, word_valid}, 16'd0);
    chk("rs_init_done", {15'd0, init_done}, 16'd0);
    chk("rs_busy", {15'd0, busy}, 16'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    expect_word("ri0", 16'h0F00);
    expect_word("ri1", 16'h0C01);
    expect_word("ri2", 16'h0900);
    chk("ri_init_done_low", {15'd0, init_done}, 16'd0);
    expect_word("ri3", 16'h0A03);
    expect_word("ri4", 16'h0B07);
    chk("ri_init_done", {15'd0, init_done}, 16'd1);
    c0 = cyc;
    expect_word("rf_d1", 16'h0188);
    expect_word("rf_d2", 16'h0277);
    expect_word("rf_d3", 16'h0366);
    expect_word("rf_d4", 16'h0455);
    expect_word("rf_d5", 16'h0544);
    expect_word("rf_d6", 16'h0633);
    expect_word("rf_d7", 16'h0722);
    expect_word("rf_d8", 16'h0811);

    // Automatic refresh from the timer, counted from init completion
    n = 0;
    while (word_valid !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("timer_delay", 16'(cyc - c0), 16'd3001);
    chk("timer_word", word_data, 16'h0188);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max7219_sched.md
Name: max7219_sched

Overview:
- Word-level controller for the MAX7219 serial link: owns power-up configuration, periodic and on-demand digit refresh, and host register writes.
- Arbitrates these three sources onto one 16-bit {addr, data} word stream with a valid/ready handshake.
- The downstream bit-serial shifter (nCS/CLK/DIN) consumes the stream and asserts word_ready when it can accept a word.
- Sits between display-facing logic (digit bytes, config) and the shifter.

Parameters:
- REFRESH_CYCLES, 1000000: clk cycles between automatic refresh requests; min 16. Counter width is $clog2(REFRESH_CYCLES).
- NUM_DIGITS, 8: digit registers refreshed per frame, 1..8; addresses 0x01..NUM_DIGITS.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- intensity  in  4  brightness value for reg 0x0A
- scan_limit  in  3  value for reg 0x0B
- decode_mode  in  8  value for reg 0x09
- digits  in  64  digit bytes; digit n (addr n+1) = digits[8n+7:8n]
- disp_update  in  1  one-cycle pulse: request a refresh frame
- cmd_valid  in  1  host raw word request
- cmd_word  in  16  host word {addr, data}
- cmd_ready  out  1  host word accepted when cmd_valid && cmd_ready
- word_valid  out  1  word_data valid to shifter
- word_data  out  16  {addr[15:8], data[7:0]}, MSB sent first by shifter
- word_ready  in  1  shifter accepts word when word_valid && word_ready
- init_done  out  1  high once the init sequence has completed
- busy  out  1  high when state != IDLE

Behaviour:
- Reset values (async, resetn low): state=INIT, index=0, word_valid=0, word_data=16'h0000, cmd_ready=0, init_done=0, busy=1, refresh_pending=0, rr_last=0, refresh counter=0, shadow config regs=0.
- Output handshake: once word_valid rises, word_data holds stable until the transfer cycle (word_valid && word_ready). word_valid is never withdrawn without a transfer. The next word may appear on the cycle after the transfer.
- States:
  - INIT: issues 0x0F00 (test off), 0x0C01 (normal op), {0x09,decode_mode}, {0x0A,0x0,intensity}, {0x0B,0x00000,scan_limit}. Values are sampled and copied into shadow regs as each word loads. After the last transfer: init_done=1, refresh_pending=1, go to IDLE.
  - IDLE: selects next job, priority fixed as CFG > {HOST, REFRESH} round-robin.
    - CFG when any input differs from its shadow.
    - HOST when cmd_valid.
    - REFRESH when refresh_pending.
  - CFG: re-sends only the changed registers, in order 0x09, 0x0A, 0x0B. Updates shadows. Returns to IDLE.
  - HOST: cmd_word is captured on acceptance and presented next cycle. After transfer, go to IDLE and set rr_last=HOST.
  - REFRESH: snapshots digits into a frame buffer at frame entry. Sends {n+1, byte n} for n=0..NUM_DIGITS-1. After the last transfer, clear rr_last and return to IDLE. The frame is atomic: no host or cfg word is interleaved.
- cmd_ready is combinational: high only in IDLE with init_done=1, no CFG pending, and (refresh_pending=0 or rr_last=REFRESH).
- Round-robin: when HOST and REFRESH are both pending, the source not served last wins. A host stream therefore cannot starve refresh, and vice versa.
- Latency:
  - IDLE decision -> word_valid high on the next clk.
  - Host word acceptance -> word_valid one cycle later.
- Refresh timer:
  - Free-runs after init_done. At count REFRESH_CYCLES-1 it wraps to 0 and sets refresh_pending.
  - disp_update also sets refresh_pending; requests arriving while pending merge.
  - refresh_pending clears on REFRESH entry. A request arriving during a frame re-sets it, giving one more frame afterwards.
- Inputs changing mid-frame: have no effect on the frame in progress, which uses the snapshot. Config changes during any job are serviced at the next IDLE.
- Reset mid-word: word_valid drops immediately. After release, the full INIT sequence restarts from word 0.
- word_ready held low indefinitely: the block stalls with outputs stable. The refresh timer keeps counting, and its request merges into refresh_pending.

Test Plan:
- Release reset, word_ready=1, intensity=4'h8, scan_limit=7, decode_mode=0 -> words 0F00, 0C01, 0900, 0A08, 0B07, then 0101..0808 frame carrying digits bytes; init_done rises after the 0B07 transfer.
- After init, pulse disp_update with digits=64'h0807060504030201 -> exactly 8 words 0101, 0202, ..., 0808; busy then low.
- Change intensity 8->3 during a refresh frame -> frame completes unchanged, then the single word 0A03; no 09/0B words.
- Hold cmd_valid with cmd_word=16'h0A0F and pulse disp_update in the same IDLE cycle (rr_last=REFRESH) -> 0A0F first, then the full frame; the next queued host word waits for frame end.
- Drive word_ready low for 50 cycles mid-frame -> word_valid and word_data stable throughout; no word dropped or duplicated after release.
- Assert resetn low during the 3rd digit word, then release -> word_valid drops in the same cycle; the sequence restarts at 0F00 and init_done=0 until INIT completes.
